// File: rtl/div_unit.sv
// div_unit: multicycle restoring divider (signed by default) for the DivOp/DivmOp
// start/end handshake. Quotient goes to LO and remainder to HI. A zero divisor
// skips the iterations and raises div_zero together with div_end.
//
// Optional feature macro: DIV_UNSIGNED_EN
//   When defined, the div_signed input is added and sampled with div_start.
//   div_signed=0 selects unsigned division (divu).
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   dividend, divisor   operands, sampled only when div_start is accepted in IDLE
//   div_signed          (DIV_UNSIGNED_EN only) 1 = signed, 0 = unsigned
//   div_start           request, ignored unless the unit is idle
//   hi_out / lo_out     remainder / quotient, registered, held until next result
//   busy                high from the cycle after acceptance until div_end falls
//   div_end             one-cycle completion pulse, results valid in that cycle
//   div_zero            one-cycle pulse coincident with div_end on divide-by-zero
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_signed,
`endif
    input  logic             div_start,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             div_end,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_FIX    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_DONE_Z = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, q, dvs;
    logic             sign_a, sign_b;

    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             q_bit;

`ifdef DIV_UNSIGNED_EN
    assign op_signed = div_signed;
`else
    assign op_signed = 1'b1;
`endif

    // Magnitudes wrap modulo 2^WIDTH, so the most negative value maps to itself
    // and is then treated as an unsigned magnitude by the iteration.
    assign a_neg = op_signed & dividend[WIDTH-1];
    assign b_neg = op_signed & divisor[WIDTH-1];
    assign a_abs = a_neg ? -dividend : dividend;
    assign b_abs = b_neg ? -divisor  : divisor;

    // One restoring step. The shifted remainder can reach 2*|divisor|, so it
    // carries one extra bit. No borrow out of the trial subtraction means
    // rem >= |divisor|.
    always_comb begin
        rem_sh  = {rem, q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        q_bit   = ~rem_sub[WIDTH];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            dvs      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            state <= S_DONE_Z;
                        end else begin
                            dvs    <= b_abs;
                            q      <= a_abs;
                            rem    <= '0;
                            sign_a <= a_neg;
                            sign_b <= b_neg;
                            cnt    <= CW'(WIDTH - 1);
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], q_bit};
                    if (cnt == '0) state <= S_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                S_FIX: begin
                    lo_out  <= (sign_a ^ sign_b) ? -q : q;
                    hi_out  <= sign_a ? -rem : rem;
                    div_end <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                // Results are left untouched; the pulse lands one cycle after
                // the start edge and shares the DONE cycle with normal ops.
                S_DONE_Z: begin
                    div_end  <= 1'b1;
                    div_zero <= 1'b1;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, a mid-operation
// restart attempt, asynchronous reset, and randomized operands compared against
// a plain-arithmetic reference model.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_signed = 1'b1;
    logic        div_start = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, div_end, div_zero;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .dividend(dividend),
        .divisor(divisor),
`ifdef DIV_UNSIGNED_EN
        .div_signed(div_signed),
`endif
        .div_start(div_start),
        .hi_out(hi_out),
        .lo_out(lo_out),
        .busy(busy),
        .div_end(div_end),
        .div_zero(div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // MIPS semantics: quotient truncates toward zero, remainder follows the
    // dividend; 64-bit arithmetic makes the 0x80000000 / -1 case wrap naturally.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, qq, rr;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        lo = qq[31:0];
        hi = rr[31:0];
    endtask

    // Runs one operation. inject_at >= 0 pulses div_start with other operands
    // that many cycles into the operation; it must have no effect.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int inject_at);
        logic [31:0] elo, ehi;
        int          lat;
        bit          seen, busy_ok, extra;
        if (b != 0) begin
            model(a, b, sgn, elo, ehi);
            exp_lo = elo;
            exp_hi = ehi;
        end
        @(negedge clk);
        dividend = a; divisor = b; div_signed = sgn; div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        dividend = $urandom; divisor = $urandom; div_signed = $urandom_range(0, 1);
        busy_ok = busy;
        seen = 0;
        lat = 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            if (i - 1 == inject_at) begin
                div_start = 1'b1;
                dividend = $urandom;
                divisor = $urandom_range(1, 50);
            end
            @(posedge clk);
            #1;
            div_start = 1'b0;
            lat = i;
            if (div_end) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        chk({tag, " end_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'd33);
        chk({tag, " lo"}, lo_out, exp_lo);
        chk({tag, " hi"}, hi_out, exp_hi);
        chk({tag, " div_zero"}, 32'(div_zero), 32'(b == 0));
        chk({tag, " busy_held"}, 32'(busy_ok && busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " end_pulse"}, 32'(div_end), 32'd0);
        chk({tag, " busy_drop"}, 32'(busy), 32'd0);
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            extra = extra | div_end | div_zero;
        end
        chk({tag, " no_extra_end"}, 32'(extra), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        #1;
        chk("rst lo", lo_out, 32'd0);
        chk("rst hi", hi_out, 32'd0);
        chk("rst ctl", {29'd0, busy, div_end, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_div("t1 7/2", 32'd7, 32'd2, 1'b1, -1);
        chk("t1 lo const", lo_out, 32'h3);
        chk("t1 hi const", hi_out, 32'h1);
        do_div("t3 div0", 32'h12345678, 32'd0, 1'b1, -1);
        chk("t3 lo kept", lo_out, 32'h3);
        chk("t3 hi kept", hi_out, 32'h1);
        do_div("t2 -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, -1);
        chk("t2a lo const", lo_out, 32'hFFFFFFFD);
        chk("t2a hi const", hi_out, 32'hFFFFFFFF);
        do_div("t2 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, -1);
        chk("t2b lo const", lo_out, 32'hFFFFFFFD);
        chk("t2b hi const", hi_out, 32'h1);
        do_div("t4 min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, -1);
        chk("t4a lo const", lo_out, 32'h80000000);
        chk("t4a hi const", hi_out, 32'h0);
        do_div("t4 min/1", 32'h80000000, 32'd1, 1'b1, -1);
        do_div("t5 inject", 32'd1000, 32'd3, 1'b1, 5);
        chk("t5 lo const", lo_out, 32'd333);
        chk("t5 hi const", hi_out, 32'd1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        dividend = 32'd12345; divisor = 32'd7; div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t6 rst lo", lo_out, 32'd0);
        chk("t6 rst hi", hi_out, 32'd0);
        chk("t6 rst ctl", {29'd0, busy, div_end, div_zero}, 32'd0);
        exp_lo = '0;
        exp_hi = '0;
        @(negedge clk);
        reset = 1'b1;
        do_div("t6 100/7", 32'd100, 32'd7, 1'b1, -1);
        chk("t6 lo const", lo_out, 32'd14);
        chk("t6 hi const", hi_out, 32'd2);

`ifdef DIV_UNSIGNED_EN
        do_div("t7 divu", 32'hFFFFFFFE, 32'd2, 1'b0, -1);
        chk("t7 lo const", lo_out, 32'h7FFFFFFF);
        chk("t7 hi const", hi_out, 32'h0);
`endif

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'd1;
                3:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
`ifdef DIV_UNSIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b1;
`endif
            do_div("rand", ra, rb, rs, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
